// File: rtl/axicb_mst_wr_router.sv
// Per-master write router: fans AW out to the decoded slave, remembers the target in an
// in-order FIFO and steers each following W burst to it, sinking bursts with an illegal target.
module axicb_mst_wr_router #(
    parameter int unsigned       SLV_NB          = 4,
    parameter logic [SLV_NB-1:0] MST_ROUTES      = 4'b1111,
    parameter int unsigned       MST_OSTDREQ_NUM = 4,
    parameter int unsigned       AWCH_W          = 8,
    parameter int unsigned       WCH_W           = 8
) (
    input  logic                                     aclk,
    input  logic                                     srst,
    input  logic                                     s_awvalid,
    output logic                                     s_awready,
    input  logic [AWCH_W-1:0]                        s_awch,
    input  logic [SLV_NB-1:0]                        s_awslv,
    input  logic                                     s_wvalid,
    output logic                                     s_wready,
    input  logic                                     s_wlast,
    input  logic [WCH_W-1:0]                         s_wch,
    output logic [SLV_NB-1:0]                        m_awvalid,
    input  logic [SLV_NB-1:0]                        m_awready,
    output logic [AWCH_W-1:0]                        m_awch,
    output logic [SLV_NB-1:0]                        m_wvalid,
    input  logic [SLV_NB-1:0]                        m_wready,
    output logic                                     m_wlast,
    output logic [WCH_W-1:0]                         m_wch,
    output logic                                     decerr,
    output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0]     ostd_cnt
);

    localparam int unsigned DEPTH = MST_OSTDREQ_NUM;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [SLV_NB-1:0] fifo_q [DEPTH];
    logic [SLV_NB-1:0] fifo_d [DEPTH];

    logic [SLV_NB-1:0] tgt;
    logic [SLV_NB-1:0] entry;
    logic [SLV_NB-1:0] head;
    logic              aw_legal;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Payloads are broadcast; only the valids are steered.
    assign m_awch   = s_awch;
    assign m_wch    = s_wch;
    assign m_wlast  = s_wlast;
    assign ostd_cnt = cnt_q;

    // AW side: legalise the decoded target and hand-shake with the selected slave.
    always_comb begin
        tgt       = s_awslv & MST_ROUTES;
        aw_legal  = (tgt != '0) && ((tgt & (tgt - SLV_NB'(1))) == '0);
        full      = (cnt_q == CNT_W'(DEPTH));
        empty     = (cnt_q == '0);
        entry     = aw_legal ? tgt : '0;
        m_awvalid = '0;
        s_awready = 1'b0;
        if (!full && !srst) begin
            s_awready = aw_legal ? |(tgt & m_awready) : 1'b1;
            if (s_awvalid && aw_legal) begin
                m_awvalid = tgt;
            end
        end
        push   = s_awvalid && s_awready;
        decerr = push && !aw_legal;
    end

    // W side: the head entry picks the slave; an all-zero entry sinks the burst.
    always_comb begin
        head     = fifo_q[rptr_q];
        m_wvalid = '0;
        s_wready = 1'b0;
        if (!empty && !srst) begin
            s_wready = (head == '0) ? 1'b1 : |(head & m_wready);
            if (s_wvalid) begin
                m_wvalid = head;
            end
        end
        pop = s_wvalid && s_wready && s_wlast;
    end

    // Pointer, occupancy and storage next-state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wptr_q] = entry;
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entries are only read while occupied, so storage needs no reset.
    always_ff @(posedge aclk) begin
        fifo_q <= fifo_d;
    end

endmodule
